// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared encodings and constants for the DDS waveform core
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } waveSel_t;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Half of full scale for an unsigned DAC code of the given width
  function automatic int unsigned midScale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  localparam logic [7:0] MIDSCALE = 8'(midScale(8));

endpackage

// File: rtl/dds_sine_rom.sv
// rtl/dds_sine_rom.sv - quarter-wave sine magnitude table with registered read
module dds_sine_rom #(
  parameter int LUT_AW = 8,
  parameter int DATA_W = 8
) (
  input  logic              Fg_CLK,
  input  logic [LUT_AW-3:0] Addr,
  output logic [DATA_W-2:0] Data
);

  localparam int  QW  = 2 ** (LUT_AW - 2);
  localparam real AMP = real'((2 ** (DATA_W - 1)) - 1);
  localparam real TWO_PI = 6.283185307179586;

  // Rounded magnitude of the first quadrant; the peak entry (index QW) is
  // supplied by the caller, so the table stops one short of it.
  function automatic logic [DATA_W-2:0] sineMag(input int i);
    real x;
    x = AMP * $sin(TWO_PI * real'(i) / real'(2 ** LUT_AW));
    return (DATA_W - 1)'($rtoi(x + 0.5));
  endfunction

  logic [DATA_W-2:0] quarterTab [QW];

  for (genvar g = 0; g < QW; g++) begin : g_tab
    assign quarterTab[g] = sineMag(g);
  end

  // Registered table read; contents are constant so no reset is needed
  always_ff @(posedge Fg_CLK) begin
    Data <= quarterTab[Addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - DDS waveform core; DDS_SYNC_OUT_EN enables the Sync wrap marker
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 8,
  parameter int LUT_AW  = 8
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic               Ready,
  input  logic               Enable,
  input  logic [PHASE_W-1:0] TuneWord,
  input  logic               TuneLoad,
  input  logic [1:0]         WaveSel,
  output logic [DATA_W-1:0]  DacData,
  output logic               DacValid,
  output logic               Sync
);

  localparam logic [DATA_W-1:0] MID = DATA_W'(midScale(DATA_W));

  logic [0:0]         state;
  logic [PHASE_W-1:0] shadow;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   sum;
  logic               runEn;
  waveSel_t           activeSel;
  waveSel_t           nextSel;

  // Stage 1 (after accumulation)
  waveSel_t           sel1;
  logic               v1;

  // Stage 2 (after waveform / ROM register)
  waveSel_t           sel2;
  logic               v2;
  logic [DATA_W-1:0]  wave2;
  logic               peak2;
  logic               neg2;
  logic [DATA_W-2:0]  romData;

  logic [DATA_W-1:0]  waveRaw;
  logic [DATA_W-1:0]  triBits;
  logic [LUT_AW-1:0]  lutK;
  logic [LUT_AW-3:0]  lutIdx;
  logic [LUT_AW-3:0]  lutIdxNeg;
  logic [LUT_AW-3:0]  romAddr;
  logic               peak;
  logic               neg;
  logic [DATA_W-2:0]  sineMag;
  logic [DATA_W-1:0]  sineVal;

  assign runEn   = (state == ST_RUN) && Enable;
  assign sum     = {1'b0, phase} + {1'b0, shadow};
  // A wrapping sample picks up the requested select; otherwise keep the period's select
  assign nextSel = sum[PHASE_W] ? waveSel_t'(WaveSel) : activeSel;

  // Tuning shadow register, loadable in any state
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      shadow <= '0;
    end else if (TuneLoad) begin
      shadow <= TuneWord;
    end
  end

  // Control FSM, phase accumulator and select tracking
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ST_WAIT;
      phase     <= '0;
      activeSel <= WAVE_SINE;
      sel1      <= WAVE_SINE;
      v1        <= 1'b0;
    end else begin
      v1 <= 1'b0;
      if (state == ST_WAIT) begin
        activeSel <= waveSel_t'(WaveSel);
        if (Ready) begin
          state <= ST_RUN;
        end
      end else if (runEn) begin
        phase     <= sum[PHASE_W-1:0];
        activeSel <= nextSel;
        sel1      <= nextSel;
        v1        <= 1'b1;
      end
    end
  end

  // Sine address folding: odd quadrants mirror the index, upper half negates
  assign lutK      = phase[PHASE_W-1 -: LUT_AW];
  assign lutIdx    = lutK[LUT_AW-3:0];
  assign lutIdxNeg = ~lutIdx + 1'b1;
  assign romAddr   = lutK[LUT_AW-2] ? lutIdxNeg : lutIdx;
  assign peak      = lutK[LUT_AW-2] && (lutIdx == '0);
  assign neg       = lutK[LUT_AW-1];
  assign triBits   = phase[PHASE_W-2 -: DATA_W];

  // Non-sine waveforms derived directly from the updated phase
  always_comb begin
    waveRaw = phase[PHASE_W-1 -: DATA_W];
    case (sel1)
      WAVE_SQUARE: waveRaw = {DATA_W{phase[PHASE_W-1]}};
      WAVE_TRI:    waveRaw = phase[PHASE_W-1] ? ~triBits : triBits;
      default:     waveRaw = phase[PHASE_W-1 -: DATA_W];
    endcase
  end

  dds_sine_rom #(
    .LUT_AW (LUT_AW),
    .DATA_W (DATA_W)
  ) u_sine_rom (
    .Fg_CLK (Fg_CLK),
    .Addr   (romAddr),
    .Data   (romData)
  );

  // Waveform stage: register the wave value alongside the ROM read
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      v2    <= 1'b0;
      sel2  <= WAVE_SINE;
      wave2 <= MID;
      peak2 <= 1'b0;
      neg2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sel2  <= sel1;
        wave2 <= waveRaw;
        peak2 <= peak;
        neg2  <= neg;
      end
    end
  end

  assign sineMag = peak2 ? '1 : romData;
  assign sineVal = neg2 ? (MID - {1'b0, sineMag}) : (MID + {1'b0, sineMag});

  // Output stage: present one sample per valid with a single-cycle strobe
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      DacData  <= MID;
      DacValid <= 1'b0;
    end else begin
      DacValid <= v2;
      if (v2) begin
        DacData <= (sel2 == WAVE_SINE) ? sineVal : wave2;
      end
    end
  end

`ifdef DDS_SYNC_OUT_EN
  logic w1;
  logic w2;

  // Carry the wrap flag down the pipeline with its sample
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      w1   <= 1'b0;
      w2   <= 1'b0;
      Sync <= 1'b0;
    end else begin
      if (runEn) begin
        w1 <= sum[PHASE_W];
      end
      if (v1) begin
        w2 <= w1;
      end
      Sync <= v2 & w2;
    end
  end
`else
  assign Sync = 1'b0;
`endif

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - scoreboard bench for dds_wave_gen
module tb_dds_wave_gen;

`ifdef DDS_SYNC_OUT_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic        Fg_CLK   = 1'b0;
  logic        RESETn   = 1'b1;
  logic        Ready    = 1'b0;
  logic        Enable   = 1'b0;
  logic        TuneLoad = 1'b0;
  logic [23:0] TuneWord = '0;
  logic [1:0]  WaveSel  = 2'd0;
  logic [7:0]  DacData;
  logic        DacValid;
  logic        Sync;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] data;
    logic       sync;
    int         issue;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  logic [7:0] sqPat  [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
  logic [7:0] triPat [8]  = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00};
  logic [7:0] sinPat [4]  = '{8'hFF, 8'h80, 8'h01, 8'h80};

  dds_wave_gen dut (
    .Fg_CLK   (Fg_CLK),
    .RESETn   (RESETn),
    .Ready    (Ready),
    .Enable   (Enable),
    .TuneWord (TuneWord),
    .TuneLoad (TuneLoad),
    .WaveSel  (WaveSel),
    .DacData  (DacData),
    .DacValid (DacValid),
    .Sync     (Sync)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  always @(posedge Fg_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe pops one expected sample
  always @(negedge Fg_CLK) begin
    if (RESETn) begin
      if (DacValid === 1'b1) begin
        if (expQ.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          monE = expQ.pop_front();
          check("dac_data", 32'(DacData), 32'(monE.data));
          check("sync", 32'(Sync), 32'(monE.sync));
          check("latency", 32'(cyc - monE.issue), 32'd3);
        end
      end else begin
        check("sync_idle", 32'(Sync), 32'd0);
      end
    end
  end

  task automatic enableCycle(input logic [7:0] data, input logic wrap);
    exp_t e;
    e.data  = data;
    e.sync  = wrap & SYNC_ON;
    e.issue = cyc;
    expQ.push_back(e);
    Enable = 1'b1;
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic drain();
    Enable = 1'b0;
    repeat (6) @(posedge Fg_CLK);
    #1;
    check("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    RESETn = 1'b0;
    Enable = 1'b0;
    Ready  = 1'b0;
    #1;
    check("rst_data", 32'(DacData), 32'h80);
    check("rst_valid", 32'(DacValid), 32'd0);
    check("rst_sync", 32'(Sync), 32'd0);
    repeat (2) @(posedge Fg_CLK);
    #1;
    expQ.delete();
    RESETn = 1'b1;
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic startRun(input logic [1:0] sel, input logic [23:0] tw);
    doReset();
    WaveSel = sel;
    Ready   = 1'b1;
    @(posedge Fg_CLK);
    #1;
    Ready    = 1'b0;
    TuneWord = tw;
    TuneLoad = 1'b1;
    @(posedge Fg_CLK);
    #1;
    TuneLoad = 1'b0;
  endtask

  initial begin
    #2;
    // No Ready: Enable is ignored
    doReset();
    Enable = 1'b1;
    repeat (100) begin
      @(negedge Fg_CLK);
      check("idle_valid", 32'(DacValid), 32'd0);
      check("idle_data", 32'(DacData), 32'h80);
    end
    @(posedge Fg_CLK);
    #1;
    Enable = 1'b0;

    // Sawtooth full period, continuous Enable
    startRun(2'd2, 24'h010000);
    for (int i = 0; i < 256; i++) enableCycle(8'((i + 1) & 8'hFF), i == 255);
    drain();

    // Square, two periods
    startRun(2'd1, 24'h100000);
    for (int i = 0; i < 32; i++) enableCycle(sqPat[i % 16], (i % 16) == 15);
    drain();

    // Triangle, one period
    startRun(2'd3, 24'h200000);
    for (int i = 0; i < 8; i++) enableCycle(triPat[i], i == 7);
    drain();

    // Sine, then select change mid-period takes effect on the wrap sample
    startRun(2'd0, 24'h400000);
    for (int i = 0; i < 5; i++) enableCycle(sinPat[i % 4], i == 3);
    WaveSel = 2'd2;
    enableCycle(8'h80, 1'b0);
    enableCycle(8'h01, 1'b0);
    enableCycle(8'h00, 1'b1);
    enableCycle(8'h40, 1'b0);
    enableCycle(8'h80, 1'b0);
    drain();

    // Tuning word zero: frozen phase, strobes still emitted
    startRun(2'd2, 24'h000000);
    for (int i = 0; i < 4; i++) enableCycle(8'h00, 1'b0);
    drain();

    // TuneLoad coinciding with Enable, plus gaps between samples
    startRun(2'd2, 24'h010000);
    enableCycle(8'h01, 1'b0);
    enableCycle(8'h02, 1'b0);
    TuneWord = 24'h020000;
    TuneLoad = 1'b1;
    enableCycle(8'h03, 1'b0);
    TuneLoad = 1'b0;
    enableCycle(8'h05, 1'b0);
    Enable = 1'b0;
    @(posedge Fg_CLK);
    #1;
    enableCycle(8'h07, 1'b0);
    Enable = 1'b0;
    repeat (2) @(posedge Fg_CLK);
    #1;
    enableCycle(8'h09, 1'b0);
    drain();

    // Reset during a continuous run
    startRun(2'd2, 24'h010000);
    for (int i = 0; i < 10; i++) enableCycle(8'(i + 1), 1'b0);
    RESETn = 1'b0;
    #1;
    check("midrst_data", 32'(DacData), 32'h80);
    check("midrst_valid", 32'(DacValid), 32'd0);
    expQ.delete();
    repeat (2) @(posedge Fg_CLK);
    #1;
    RESETn = 1'b1;
    repeat (20) begin
      @(negedge Fg_CLK);
      check("postrst_valid", 32'(DacValid), 32'd0);
      check("postrst_data", 32'(DacData), 32'h80);
    end
    @(posedge Fg_CLK);
    #1;
    Enable = 1'b0;
    Ready  = 1'b1;
    @(posedge Fg_CLK);
    #1;
    Ready    = 1'b0;
    TuneWord = 24'h010000;
    TuneLoad = 1'b1;
    @(posedge Fg_CLK);
    #1;
    TuneLoad = 1'b0;
    for (int i = 0; i < 3; i++) enableCycle(8'(i + 1), 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
